// File: rtl/parking_counter.sv
// parking_counter: occupancy counter for a car park entrance with two light beams.
//
// A car entering breaks the outer beam (a) first, then both beams, then only the
// inner beam (b), then neither. An exit produces the mirror sequence. Each raw
// beam is synchronized, then debounced. A sequence FSM recognizes complete
// passes and drives a saturating binary counter plus a parallel BCD counter.
//
// Parameters:
//   CAPACITY        maximum occupancy, 1..99
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a beam change, >= 1
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   sensor_a   raw outer beam, 1 = blocked, asynchronous to clk
//   sensor_b   raw inner beam, 1 = blocked, asynchronous to clk
//   tens_digit BCD tens of occupancy
//   ones_digit BCD ones of occupancy
//   count      binary occupancy
//   full       count == CAPACITY (registered)
//   empty      count == 0 (registered)
//   car_in     one-cycle pulse per completed entry
//   car_out    one-cycle pulse per completed exit
//   error      one-cycle pulse alongside a rejected entry (full) or exit (empty)

module parking_counter #(
    parameter int unsigned CAPACITY        = 99,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic [6:0] count,
    output logic       full,
    output logic       empty,
    output logic       car_in,
    output logic       car_out,
    output logic       error
);

    // Debounce counter only ever needs to hold DEBOUNCE_CYCLES-1.
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] CapVal = 7'(CAPACITY);

    typedef enum logic [2:0] {
        StIdle,
        StEnt1,
        StEnt2,
        StEnt3,
        StExt1,
        StExt2,
        StExt3,
        StWaitClr
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic a_meta_q, a_sync_q;
    logic b_meta_q, b_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_meta_q <= 1'b0;
            a_sync_q <= 1'b0;
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            a_meta_q <= sensor_a;
            a_sync_q <= a_meta_q;
            b_meta_q <= sensor_b;
            b_sync_q <= b_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers: a change is accepted only after the synced value has
    // differed from the debounced value for DEBOUNCE_CYCLES consecutive edges.
    // ------------------------------------------------------------------
    logic           deb_a_q, deb_a_d;
    logic           deb_b_q, deb_b_d;
    logic [DbW-1:0] cnt_a_q, cnt_a_d;
    logic [DbW-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        deb_a_d = deb_a_q;
        cnt_a_d = '0;
        if (a_sync_q != deb_a_q) begin
            if (cnt_a_q == DbLast) begin
                deb_a_d = a_sync_q;
            end else begin
                cnt_a_d = cnt_a_q + DbW'(1);
            end
        end
    end

    always_comb begin
        deb_b_d = deb_b_q;
        cnt_b_d = '0;
        if (b_sync_q != deb_b_q) begin
            if (cnt_b_q == DbLast) begin
                deb_b_d = b_sync_q;
            end else begin
                cnt_b_d = cnt_b_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_a_q <= 1'b0;
            deb_b_q <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            deb_a_q <= deb_a_d;
            deb_b_q <= deb_b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Pass-recognition FSM on the debounced pair {a,b}
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic       in_d, out_d;
    logic [1:0] ab;

    assign ab = {deb_a_q, deb_b_q};

    always_comb begin
        state_d = state_q;
        in_d    = 1'b0;
        out_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                case (ab)
                    2'b10:   state_d = StEnt1;
                    2'b01:   state_d = StExt1;
                    2'b11:   state_d = StWaitClr;
                    default: state_d = StIdle;
                endcase
            end
            StEnt1: begin
                case (ab)
                    2'b11:   state_d = StEnt2;
                    2'b00:   state_d = StIdle;
                    2'b01:   state_d = StWaitClr;
                    default: state_d = StEnt1;
                endcase
            end
            StEnt2: begin
                case (ab)
                    2'b01:   state_d = StEnt3;
                    2'b10:   state_d = StEnt1;
                    2'b00:   state_d = StIdle;
                    default: state_d = StEnt2;
                endcase
            end
            StEnt3: begin
                case (ab)
                    2'b00: begin
                        state_d = StIdle;
                        in_d    = 1'b1;
                    end
                    2'b11:   state_d = StEnt2;
                    2'b10:   state_d = StWaitClr;
                    default: state_d = StEnt3;
                endcase
            end
            StExt1: begin
                case (ab)
                    2'b11:   state_d = StExt2;
                    2'b00:   state_d = StIdle;
                    2'b10:   state_d = StWaitClr;
                    default: state_d = StExt1;
                endcase
            end
            StExt2: begin
                case (ab)
                    2'b10:   state_d = StExt3;
                    2'b01:   state_d = StExt1;
                    2'b00:   state_d = StIdle;
                    default: state_d = StExt2;
                endcase
            end
            StExt3: begin
                case (ab)
                    2'b00: begin
                        state_d = StIdle;
                        out_d   = 1'b1;
                    end
                    2'b11:   state_d = StExt2;
                    2'b01:   state_d = StWaitClr;
                    default: state_d = StExt3;
                endcase
            end
            StWaitClr: begin
                // Illegal or unrecognized pattern: wait for both beams clear.
                if (ab == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            car_in  <= 1'b0;
            car_out <= 1'b0;
        end else begin
            state_q <= state_d;
            car_in  <= in_d;
            car_out <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy: binary and BCD counters kept in lockstep
    // ------------------------------------------------------------------
    logic [6:0] count_d;
    logic [3:0] tens_d, ones_d;
    logic       full_d, empty_d;

    // full/empty already reflect the count the pulse is applied to.
    assign error = (car_in & full) | (car_out & empty);

    always_comb begin
        count_d = count;
        tens_d  = tens_digit;
        ones_d  = ones_digit;
        if (car_in && !full) begin
            count_d = count + 7'd1;
            if (ones_digit == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_digit + 4'd1;
            end else begin
                ones_d = ones_digit + 4'd1;
            end
        end else if (car_out && !empty) begin
            count_d = count - 7'd1;
            if (ones_digit == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_digit - 4'd1;
            end else begin
                ones_d = ones_digit - 4'd1;
            end
        end
        full_d  = (count_d == CapVal);
        empty_d = (count_d == 7'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 7'd0;
            tens_digit <= 4'd0;
            ones_digit <= 4'd0;
            full       <= 1'b0;
            empty      <= 1'b1;
        end else begin
            count      <= count_d;
            tens_digit <= tens_d;
            ones_digit <= ones_d;
            full       <= full_d;
            empty      <= empty_d;
        end
    end

endmodule

// File: tb/tb_parking_counter.sv
// Bench for parking_counter: two instances (CAPACITY=3 and CAPACITY=99, both with
// DEBOUNCE_CYCLES=4) share sensors and reset. Each pass pushes its expected
// pulse/count outcome; a monitor pops and compares when a pulse appears.

module tb_parking_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sensor_a;
    logic sensor_b;

    logic [3:0] t3, o3, t99, o99;
    logic [6:0] c3, c99;
    logic       f3, e3, i3, x3, r3;
    logic       f99, e99, i99, x99, r99;

    parking_counter #(.CAPACITY(3), .DEBOUNCE_CYCLES(4)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .sensor_a   (sensor_a),
        .sensor_b   (sensor_b),
        .tens_digit (t3),
        .ones_digit (o3),
        .count      (c3),
        .full       (f3),
        .empty      (e3),
        .car_in     (i3),
        .car_out    (x3),
        .error      (r3)
    );

    parking_counter #(.CAPACITY(99), .DEBOUNCE_CYCLES(4)) dut99 (
        .clk        (clk),
        .reset      (reset),
        .sensor_a   (sensor_a),
        .sensor_b   (sensor_b),
        .tens_digit (t99),
        .ones_digit (o99),
        .count      (c99),
        .full       (f99),
        .empty      (e99),
        .car_in     (i99),
        .car_out    (x99),
        .error      (r99)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    typedef struct {
        bit is_in;
        bit err3;
        int cnt3;
        bit err99;
        int cnt99;
    } want_t;

    want_t sb[$];
    int m3  = 0;
    int m99 = 0;

    // Expected outcome of one completed pass for both capacities.
    task automatic push_pass(input bit is_in);
        want_t w;
        w.is_in = is_in;
        if (is_in) begin
            if (m3 < 3) begin m3++; w.err3 = 0; end else w.err3 = 1;
            if (m99 < 99) begin m99++; w.err99 = 0; end else w.err99 = 1;
        end else begin
            if (m3 > 0) begin m3--; w.err3 = 0; end else w.err3 = 1;
            if (m99 > 0) begin m99--; w.err99 = 0; end else w.err99 = 1;
        end
        w.cnt3  = m3;
        w.cnt99 = m99;
        sb.push_back(w);
    endtask

    // Apply {a,b} at a falling edge and hold it for n cycles.
    task automatic drive(input bit a, input bit b, input int n);
        @(negedge clk);
        sensor_a = a;
        sensor_b = b;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic pass(input bit is_in, input string tag);
        push_pass(is_in);
        if (is_in) begin
            drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10);
        end else begin
            drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 10);
        end
        check_eq({tag, "_seen"}, sb.size(), 0);
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq({tag, "_cnt3"}, c3, 0);
        check_eq({tag, "_dig3"}, {t3, o3}, 0);
        check_eq({tag, "_flags3"}, {f3, e3, i3, x3, r3}, 5'b01000);
        check_eq({tag, "_cnt99"}, c99, 0);
        check_eq({tag, "_dig99"}, {t99, o99}, 0);
        check_eq({tag, "_flags99"}, {f99, e99, i99, x99, r99}, 5'b01000);
        reset = 1'b0;
        m3  = 0;
        m99 = 0;
    endtask

    // Monitor: every pulse must match the oldest pending expectation.
    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (!reset && (i3 || x3 || i99 || x99)) begin
                check_eq("pulse_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    w = sb.pop_front();
                    check_eq("in3", i3, w.is_in);
                    check_eq("out3", x3, !w.is_in);
                    check_eq("err3", r3, w.err3);
                    check_eq("in99", i99, w.is_in);
                    check_eq("out99", x99, !w.is_in);
                    check_eq("err99", r99, w.err99);
                    @(negedge clk);
                    check_eq("count3", c3, w.cnt3);
                    check_eq("tens3", t3, w.cnt3 / 10);
                    check_eq("ones3", o3, w.cnt3 % 10);
                    check_eq("full3", f3, w.cnt3 == 3);
                    check_eq("empty3", e3, w.cnt3 == 0);
                    check_eq("count99", c99, w.cnt99);
                    check_eq("tens99", t99, w.cnt99 / 10);
                    check_eq("ones99", o99, w.cnt99 % 10);
                    check_eq("full99", f99, w.cnt99 == 99);
                    check_eq("empty99", e99, w.cnt99 == 0);
                    check_eq("one_cycle", {i3, x3, r3, i99, x99, r99}, 0);
                end
            end
        end
    end

    initial begin
        int  lat;
        bit  rose;
        reset    = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_and_check("rst0");

        // Debounce latency on the first entry, then complete it.
        push_pass(1);
        @(negedge clk);
        sensor_a = 1'b1;
        sensor_b = 1'b0;
        lat = 0;
        while (lat < 40 && dut3.deb_a_q !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("deb_latency", lat, 6);
        check_eq("ent1_count", c3, 0);
        check_eq("ent1_empty", e3, 1);
        repeat (4) @(negedge clk);
        drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 10);
        check_eq("entry1_seen", sb.size(), 0);
        check_eq("entry1_ones", o3, 1);
        check_eq("entry1_empty", e3, 0);

        // Fill CAPACITY=3, fourth entry rejected.
        pass(1, "entry2");
        pass(1, "entry3");
        check_eq("full_after3", f3, 1);
        pass(1, "entry4");
        check_eq("hold_at_cap", c3, 3);

        // Exit while empty.
        reset_and_check("rst1");
        pass(0, "exit_empty");

        // Glitch shorter than the debounce window.
        rose = 0;
        @(negedge clk);
        sensor_a = 1'b1;
        repeat (3) @(negedge clk);
        sensor_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut3.deb_a_q) rose = 1;
        end
        check_eq("glitch_deb", rose, 0);

        // Aborted entry returns to idle with no pulse.
        drive(1, 0, 10);
        drive(0, 0, 10);
        check_eq("abort_idle", dut3.state_q, 0);
        pass(1, "after_abort");
        pass(0, "exit_one");

        // BCD rollover on the CAPACITY=99 instance.
        reset_and_check("rst2");
        for (int i = 0; i < 9; i++) pass(1, "fill");
        check_eq("at9_ones", o99, 9);
        for (int i = 0; i < 10; i++) pass(1, "bcd");
        check_eq("at19_tens", t99, 1);
        check_eq("at19_ones", o99, 9);
        pass(0, "bcd_down");

        // Reset in the middle of an entry.
        drive(1, 0, 10);
        drive(1, 1, 10);
        check_eq("in_ent2", dut99.state_q, 2);
        reset_and_check("rst_mid");
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(0, 0, 20);
        check_eq("post_mid_cnt99", c99, 0);
        check_eq("post_mid_cnt3", c3, 0);

        check_eq("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
